arbitro_rr_param: RTL and testbench

Parametrised arbiter between N_CH input FIFOs (naranja) and N_CH output FIFOs (morado) in the PCIe transaction-layer datapath. Each cycle it grants at most one non-empty input whose destination output is not almost-full, pops that input, and pushes the word to the output named by the word's destination field one cycle later. It supports fixed-priority or round-robin selection, switchable at run time, and reports its FSM state and idle status to the top-level controller.

---
 rtl/arbitro_pkg.sv | 24 ++
 rtl/arbitro_picker.sv | 50 +++++
 rtl/arbitro_rr_param.sv | 120 ++++++++++++
 tb/tb_arbitro_rr_param.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Purpose: shared FSM encodings and width helper for the round-robin/fixed-priority arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arbitro_pkg;

    // One-hot controller-visible FSM states
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    // Ceiling log2 for deriving index widths from channel counts
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arbitro_picker.sv
// Purpose: combinational one-of-N picker, fixed priority (lowest index) or round-robin from ptr+1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; ineligible channels are masked before they reach the picker.
module arbitro_picker #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_rr_mode,
    output logic [N_CH-1:0]  o_grant,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any_grant
);

    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan candidates in search order; the first eligible one wins.
    // N_CH is a power of two, so truncating to IDX_W gives the wrap-around.
    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_rr_mode) begin
                w_cand = i_ptr + IDX_W'(k + 1);
            end else begin
                w_cand = IDX_W'(k);
            end
            if (!w_found && i_elig[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // Expand the winning index to a one-hot grant vector
    always_comb begin
        o_grant = '0;
        if (w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_winner    = w_idx;
    assign o_any_grant = w_found;

endmodule

// File: rtl/arbitro_rr_param.sv
// Purpose: arbitrate N_CH input FIFOs onto N_CH output FIFOs, routing each word by its top DEST_W bits.
// Latency: combinational pop, push and data registered 1 cycle later; 1 word/cycle sustained.
// Backpressure: an input is skipped while its destination reports almost-full (needs >=2 slots of slack).
module arbitro_rr_param
    import arbitro_pkg::*;
#(
    parameter int  N_CH   = 4,
    parameter int  DATA_W = 10,
    localparam int DEST_W = clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rr_mode,
    input  logic [N_CH-1:0]          in_empty,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          out_almost_full,
    output logic [N_CH-1:0]          in_pop,
    output logic [N_CH-1:0]          out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [DEST_W-1:0]        grant_id,
    output logic [3:0]               state,
    output logic                     idle
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEST_W-1:0]   r_ptr;
    logic [N_CH-1:0]     r_out_push;
    logic [DATA_W-1:0]   r_out_data;
    logic [DEST_W-1:0]   r_grant_id;
    logic                r_idle;

    logic [DATA_W-1:0]   w_word [N_CH];
    logic [DEST_W-1:0]   w_dest [N_CH];
    logic [N_CH-1:0]     w_elig;
    logic                w_arb_en;
    logic [N_CH-1:0]     w_grant;
    logic [DEST_W-1:0]   w_winner;
    logic                w_any_grant;
    logic [DATA_W-1:0]   w_sel_data;
    logic [DEST_W-1:0]   w_sel_dest;
    logic [N_CH-1:0]     w_push_oh;

    // Arbitration only runs in the operational states and never while reset is held,
    // so no input is popped during start-up or in the reset cycle itself.
    assign w_arb_en = ~reset & ((r_state == ST_IDLE) | (r_state == ST_ACTIVE));

    // Per-channel head-word split, destination decode and eligibility
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_word[gi] = in_data[gi*DATA_W +: DATA_W];
        assign w_dest[gi] = w_word[gi][DATA_W-1 -: DEST_W];
        assign w_elig[gi] = w_arb_en & ~in_empty[gi] & ~out_almost_full[w_dest[gi]];
    end

    arbitro_picker #(
        .N_CH  (N_CH),
        .IDX_W (DEST_W)
    ) u_picker (
        .i_elig      (w_elig),
        .i_ptr       (r_ptr),
        .i_rr_mode   (rr_mode),
        .o_grant     (w_grant),
        .o_winner    (w_winner),
        .o_any_grant (w_any_grant)
    );

    // Pop is the raw grant: the FIFOs are first-word-fall-through, so the word is consumed this cycle
    assign in_pop     = w_grant;
    assign w_sel_data = w_word[w_winner];
    assign w_sel_dest = w_dest[w_winner];

    // Steer the push to the output named by the winning word's destination field
    always_comb begin
        w_push_oh = '0;
        if (w_any_grant) begin
            w_push_oh[w_sel_dest] = 1'b1;
        end
    end

    // Next-state decode; also feeds the registered idle flag
    always_comb begin
        w_state_nxt = ST_RESET;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   w_state_nxt = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: w_state_nxt = w_any_grant ? ST_ACTIVE : ST_IDLE;
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    // FSM, round-robin pointer and registered output stage.
    // The pointer tracks every winner in both modes so a mode switch needs no resync.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RESET;
            r_ptr      <= DEST_W'(N_CH - 1);
            r_out_push <= '0;
            r_out_data <= '0;
            r_grant_id <= '0;
            r_idle     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_push <= w_push_oh;
            r_idle     <= (w_state_nxt == ST_IDLE) & (&in_empty);
            if (w_any_grant) begin
                r_ptr      <= w_winner;
                r_out_data <= w_sel_data;
                r_grant_id <= w_winner;
            end
        end
    end

    assign out_push = r_out_push;
    assign out_data = r_out_data;
    assign grant_id = r_grant_id;
    assign state    = r_state;
    assign idle     = r_idle;

endmodule

// File: tb/tb_arbitro_rr_param.sv
module tb_arbitro_rr_param;

    localparam int N_CH   = 4;
    localparam int DATA_W = 10;
    localparam int DEST_W = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   rr_mode = 1'b0;
    logic [N_CH-1:0]        in_empty = 4'hF;
    logic [N_CH*DATA_W-1:0] in_data = '0;
    logic [N_CH-1:0]        out_almost_full = '0;
    logic [N_CH-1:0]        in_pop;
    logic [N_CH-1:0]        out_push;
    logic [DATA_W-1:0]      out_data;
    logic [DEST_W-1:0]      grant_id;
    logic [3:0]             state;
    logic                   idle;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] head [N_CH];

    always #5 clk = ~clk;

    arbitro_rr_param #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rr_mode         (rr_mode),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .in_pop          (in_pop),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant_id        (grant_id),
        .state           (state),
        .idle            (idle)
    );

    // Inputs change at posedge+1; outputs are sampled at posedge+1 or posedge+2
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_heads();
        for (int i = 0; i < N_CH; i++) begin
            in_data[i*DATA_W +: DATA_W] = head[i];
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        in_empty = 4'hF;
        out_almost_full = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_empty = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (state !== 4'b0001) begin
                n_errors++;
                $display("FAIL reset_state[%0d]: got %b expected 0001", i, state);
            end
            n_checks++;
            if (out_push !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_push[%0d]: got %b expected 0000", i, out_push);
            end
            n_checks++;
            if (idle !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: got %b expected 0", i, idle);
            end
        end
        n_checks++;
        if (out_data !== 10'h000 || grant_id !== 2'd0 || in_pop !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_regs: got data=%h gid=%0d pop=%b expected 000/0/0000", out_data, grant_id, in_pop);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== 4'b0010 || out_push !== 4'b0000) begin
            n_errors++;
            $display("FAIL init_state: got state=%b push=%b expected 0010/0000", state, out_push);
        end
        tick();
        n_checks++;
        if (state !== 4'b0100 || idle !== 1'b1 || out_push !== 4'b0000) begin
            n_errors++;
            $display("FAIL idle_state: got state=%b idle=%b push=%b expected 0100/1/0000", state, idle, out_push);
        end
        tick();
        n_checks++;
        if (state !== 4'b0100 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_hold: got state=%b idle=%b expected 0100/1", state, idle);
        end
    endtask

    task automatic test_fixed_priority();
        rr_mode = 1'b0;
        load_heads();
        in_empty = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in_pop !== 4'b0001) begin
                n_errors++;
                $display("FAIL fp_pop[%0d]: got %b expected 0001", i, in_pop);
            end
            tick();
            n_checks++;
            if (out_push !== 4'b0001 || out_data !== 10'h0AA || grant_id !== 2'd0) begin
                n_errors++;
                $display("FAIL fp_push[%0d]: got push=%b data=%h gid=%0d expected 0001/0aa/0", i, out_push, out_data, grant_id);
            end
            n_checks++;
            if (state !== 4'b1000 || idle !== 1'b0) begin
                n_errors++;
                $display("FAIL fp_state[%0d]: got state=%b idle=%b expected 1000/0", i, state, idle);
            end
        end
        in_empty = 4'hF;
        tick();
        n_checks++;
        if (out_push !== 4'b0000 || out_data !== 10'h0AA || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL fp_hold: got push=%b data=%h gid=%0d expected 0000/0aa/0", out_push, out_data, grant_id);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        rr_mode = 1'b1;
        load_heads();
        in_empty = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            int c;
            logic [3:0] e;
            c = i % 4;
            e = 4'(1 << c);
            #1;
            n_checks++;
            if (in_pop !== e) begin
                n_errors++;
                $display("FAIL rr_pop[%0d]: got %b expected %b", i, in_pop, e);
            end
            tick();
            n_checks++;
            if (out_push !== e || out_data !== head[c] || grant_id !== 2'(c)) begin
                n_errors++;
                $display("FAIL rr_push[%0d]: got push=%b data=%h gid=%0d expected %b/%h/%0d", i, out_push, out_data, grant_id, e, head[c], c);
            end
        end
    endtask

    task automatic test_backpressure();
        int seq [6] = '{2, 3, 0, 2, 3, 0};
        out_almost_full = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] e;
            e = 4'(1 << seq[i]);
            #1;
            n_checks++;
            if (in_pop !== e) begin
                n_errors++;
                $display("FAIL bp_pop[%0d]: got %b expected %b", i, in_pop, e);
            end
            tick();
            n_checks++;
            if (out_push !== e || out_data !== head[seq[i]]) begin
                n_errors++;
                $display("FAIL bp_push[%0d]: got push=%b data=%h expected %b/%h", i, out_push, out_data, e, head[seq[i]]);
            end
        end
        out_almost_full = 4'b0000;
        #1;
        n_checks++;
        if (in_pop !== 4'b0010) begin
            n_errors++;
            $display("FAIL bp_release_pop: got %b expected 0010", in_pop);
        end
        tick();
        n_checks++;
        if (out_push !== 4'b0010 || out_data !== 10'h1BB || grant_id !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_release_push: got push=%b data=%h gid=%0d expected 0010/1bb/1", out_push, out_data, grant_id);
        end
    endtask

    task automatic test_shared_dest();
        int seq [4] = '{2, 0, 2, 0};
        in_data[0*DATA_W +: DATA_W] = 10'h300;
        in_data[2*DATA_W +: DATA_W] = 10'h305;
        in_empty = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] e;
            logic [9:0] d;
            e = 4'(1 << seq[i]);
            d = (seq[i] == 0) ? 10'h300 : 10'h305;
            #1;
            n_checks++;
            if (in_pop !== e) begin
                n_errors++;
                $display("FAIL sd_pop[%0d]: got %b expected %b", i, in_pop, e);
            end
            tick();
            n_checks++;
            if (out_push !== 4'b1000 || out_data !== d) begin
                n_errors++;
                $display("FAIL sd_push[%0d]: got push=%b data=%h expected 1000/%h", i, out_push, out_data, d);
            end
        end
        out_almost_full = 4'b1000;
        #1;
        n_checks++;
        if (in_pop !== 4'b0000) begin
            n_errors++;
            $display("FAIL sd_af_pop: got %b expected 0000", in_pop);
        end
        tick();
        n_checks++;
        if (out_push !== 4'b0000 || state !== 4'b0100 || idle !== 1'b0 || out_data !== 10'h300) begin
            n_errors++;
            $display("FAIL sd_af_block: got push=%b state=%b idle=%b data=%h expected 0000/0100/0/300", out_push, state, idle, out_data);
        end
        out_almost_full = 4'b0000;
        in_empty = 4'hF;
        tick();
        n_checks++;
        if (out_push !== 4'b0000 || idle !== 1'b1 || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL sd_drain: got push=%b idle=%b gid=%0d expected 0000/1/0", out_push, idle, grant_id);
        end
    endtask

    task automatic test_reset_mid();
        load_heads();
        rr_mode = 1'b1;
        in_empty = 4'b0000;
        #1;
        n_checks++;
        if (in_pop !== 4'b0010) begin
            n_errors++;
            $display("FAIL rm_pre_pop: got %b expected 0010", in_pop);
        end
        tick();
        n_checks++;
        if (out_push !== 4'b0010 || out_data !== 10'h1BB) begin
            n_errors++;
            $display("FAIL rm_pre_push: got push=%b data=%h expected 0010/1bb", out_push, out_data);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_pop !== 4'b0000) begin
            n_errors++;
            $display("FAIL rm_pop: got %b expected 0000", in_pop);
        end
        tick();
        n_checks++;
        if (out_push !== 4'b0000 || state !== 4'b0001 || out_data !== 10'h000 || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL rm_push: got push=%b state=%b data=%h gid=%0d expected 0000/0001/000/0", out_push, state, out_data, grant_id);
        end
        reset = 1'b0;
        in_empty = 4'hF;
        tick();
        n_checks++;
        if (state !== 4'b0010 || out_push !== 4'b0000) begin
            n_errors++;
            $display("FAIL rm_init: got state=%b push=%b expected 0010/0000", state, out_push);
        end
        tick();
        n_checks++;
        if (state !== 4'b0100 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL rm_idle: got state=%b idle=%b expected 0100/1", state, idle);
        end
    endtask

    task automatic test_mode_switch();
        rr_mode = 1'b1;
        in_empty = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] e;
            e = 4'(1 << i);
            #1;
            n_checks++;
            if (in_pop !== e) begin
                n_errors++;
                $display("FAIL ms_rr_pop[%0d]: got %b expected %b", i, in_pop, e);
            end
            tick();
        end
        rr_mode = 1'b0;
        #1;
        n_checks++;
        if (in_pop !== 4'b0001) begin
            n_errors++;
            $display("FAIL ms_fp_pop: got %b expected 0001", in_pop);
        end
        tick();
        n_checks++;
        if (out_push !== 4'b0001 || grant_id !== 2'd0 || out_data !== 10'h0AA) begin
            n_errors++;
            $display("FAIL ms_fp_push: got push=%b gid=%0d data=%h expected 0001/0/0aa", out_push, grant_id, out_data);
        end
        rr_mode = 1'b1;
        #1;
        n_checks++;
        if (in_pop !== 4'b0010) begin
            n_errors++;
            $display("FAIL ms_rr_back_pop: got %b expected 0010", in_pop);
        end
        tick();
        rr_mode = 1'b0;
        #1;
        n_checks++;
        if (in_pop !== 4'b0001) begin
            n_errors++;
            $display("FAIL ms_fp_again_pop: got %b expected 0001", in_pop);
        end
        in_empty = 4'hF;
        tick();
        tick();
        n_checks++;
        if (out_push !== 4'b0000 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL ms_drain: got push=%b idle=%b expected 0000/1", out_push, idle);
        end
    endtask

    initial begin
        head[0] = 10'h0AA;
        head[1] = 10'h1BB;
        head[2] = 10'h2CC;
        head[3] = 10'h3DD;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_shared_dest();
        test_reset_mid();
        test_mode_switch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
